// File: rtl/med_countdown_scanner.sv
// Per-tick scanner: reads each medicine's time-remaining, decrements and writes it back, raises alarms at zero.
// Optional OVERRUN_CNT_EN adds a saturating counter of ticks lost while a scan and a pending tick were both active.
module med_countdown_scanner #(
    parameter int NUM_MEDS = 16,
    parameter int RD_LAT   = 1
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Tick,
    output logic       Read_En,
    output logic       Write_En,
    output logic [3:0] MedIDOut,
    output logic [3:0] TimeRemWrOut,
    input  logic [3:0] TimeRemRdIn,
    output logic       Alarm_Valid,
    output logic [3:0] Alarm_MedID,
    input  logic       Alarm_Ack,
    output logic       Busy
`ifdef OVERRUN_CNT_EN
    ,
    output logic [7:0] Overrun_Cnt
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WT, S_EV, S_WR, S_AL, S_NX} state_t;

    localparam logic [3:0] LAST    = 4'(NUM_MEDS - 1);
    localparam logic [1:0] WT_LAST = 2'(RD_LAT - 1);

    state_t     state;
    logic [3:0] idx;
    logic [3:0] v;
    logic [1:0] wt_cnt;
    logic       tick_pend;
    logic       we_q;

    // Reset is sampled on the same edge the RAM would commit a write, so the strobe is gated here.
    assign Write_En = we_q & ~Rst;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state        <= S_IDLE;
            idx          <= '0;
            v            <= '0;
            wt_cnt       <= '0;
            tick_pend    <= 1'b0;
            we_q         <= 1'b0;
            Read_En      <= 1'b0;
            MedIDOut     <= '0;
            TimeRemWrOut <= '0;
            Alarm_Valid  <= 1'b0;
            Alarm_MedID  <= '0;
            Busy         <= 1'b0;
        end else begin
            Read_En <= 1'b0;
            we_q    <= 1'b0;
            if (Alarm_Valid && Alarm_Ack)
                Alarm_Valid <= 1'b0;
            if (Tick && Busy)
                tick_pend <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (Tick || tick_pend) begin
                        tick_pend <= 1'b0;
                        idx       <= '0;
                        MedIDOut  <= '0;
                        Read_En   <= 1'b1;
                        Busy      <= 1'b1;
                        state     <= S_RD;
                    end
                end
                S_RD: begin
                    wt_cnt <= '0;
                    state  <= S_WT;
                end
                S_WT: begin
                    if (wt_cnt == WT_LAST) begin
                        v     <= TimeRemRdIn;
                        state <= S_EV;
                    end else begin
                        wt_cnt <= wt_cnt + 2'd1;
                    end
                end
                S_EV: begin
                    if (v == 4'd0) begin
                        state <= S_NX;
                    end else begin
                        TimeRemWrOut <= v - 4'd1;
                        we_q         <= 1'b1;
                        state        <= S_WR;
                    end
                end
                S_WR: state <= (v == 4'd1) ? S_AL : S_NX;
                S_AL: begin
                    // An unacknowledged alarm stalls the scan rather than being overwritten.
                    if (!Alarm_Valid) begin
                        Alarm_Valid <= 1'b1;
                        Alarm_MedID <= idx;
                        state       <= S_NX;
                    end
                end
                S_NX: begin
                    if (idx == LAST) begin
                        idx      <= '0;
                        MedIDOut <= '0;
                        Busy     <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        idx      <= idx + 4'd1;
                        MedIDOut <= idx + 4'd1;
                        Read_En  <= 1'b1;
                        state    <= S_RD;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef OVERRUN_CNT_EN
    always_ff @(posedge Clk) begin
        if (Rst)
            Overrun_Cnt <= '0;
        else if (Tick && tick_pend && Busy && (Overrun_Cnt != 8'hFF))
            Overrun_Cnt <= Overrun_Cnt + 8'd1;
    end
`else
    // Ticks arriving while one is already pending are dropped without trace.
`endif

endmodule

// File: tb/tb_med_countdown_scanner.sv
// Directed bench: DUT 0 (NUM_MEDS=3, RD_LAT=1) and DUT 1 (NUM_MEDS=16, RD_LAT=3), each with a RAM latency model.
module tb_med_countdown_scanner;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       tick [2];
    logic       ack  [2];
    logic       re   [2];
    logic       we   [2];
    logic       busy [2];
    logic       av   [2];
    logic [3:0] id   [2];
    logic [3:0] wd   [2];
    logic [3:0] rdin [2];
    logic [3:0] amid [2];
`ifdef OVERRUN_CNT_EN
    logic [7:0] ovr  [2];
`endif

    // RAM model state
    logic [3:0] mem  [2][16];
    logic [3:0] init [2][16];
    logic       ld   [2];
    logic [2:0] rv   [2];
    logic [3:0] rdq  [2][3];
    int         wr_cnt [2];
    int         re_cnt [2];
    logic [15:0] wr_seen [2];
    int         bc    [2];
    int         rises [2];
    logic       bprev [2];

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    med_countdown_scanner #(.NUM_MEDS(3), .RD_LAT(1)) u_dut0 (
        .Clk(Clk), .Rst(Rst), .Tick(tick[0]), .Read_En(re[0]), .Write_En(we[0]),
        .MedIDOut(id[0]), .TimeRemWrOut(wd[0]), .TimeRemRdIn(rdin[0]),
        .Alarm_Valid(av[0]), .Alarm_MedID(amid[0]), .Alarm_Ack(ack[0]), .Busy(busy[0])
`ifdef OVERRUN_CNT_EN
        , .Overrun_Cnt(ovr[0])
`endif
    );

    med_countdown_scanner #(.NUM_MEDS(16), .RD_LAT(3)) u_dut1 (
        .Clk(Clk), .Rst(Rst), .Tick(tick[1]), .Read_En(re[1]), .Write_En(we[1]),
        .MedIDOut(id[1]), .TimeRemWrOut(wd[1]), .TimeRemRdIn(rdin[1]),
        .Alarm_Valid(av[1]), .Alarm_MedID(amid[1]), .Alarm_Ack(ack[1]), .Busy(busy[1])
`ifdef OVERRUN_CNT_EN
        , .Overrun_Cnt(ovr[1])
`endif
    );

    // Read data is valid only in the cycle exactly RD_LAT after the Read_En cycle; 4'hE otherwise.
    assign rdin[0] = (rv[0][0] === 1'b1) ? rdq[0][0] : 4'hE;
    assign rdin[1] = (rv[1][2] === 1'b1) ? rdq[1][2] : 4'hE;

    always @(posedge Clk) begin
        for (int g = 0; g < 2; g++) begin
            rv[g]     <= {rv[g][1:0], re[g]};
            rdq[g][0] <= mem[g][id[g]];
            rdq[g][1] <= rdq[g][0];
            rdq[g][2] <= rdq[g][1];
            if (ld[g]) begin
                for (int i = 0; i < 16; i++) mem[g][i] <= init[g][i];
                wr_cnt[g]  <= 0;
                re_cnt[g]  <= 0;
                wr_seen[g] <= '0;
            end else begin
                if (re[g]) re_cnt[g] <= re_cnt[g] + 1;
                if (we[g] === 1'b1) begin
                    mem[g][id[g]]     <= wd[g];
                    wr_cnt[g]         <= wr_cnt[g] + 1;
                    wr_seen[g][id[g]] <= 1'b1;
                end
            end
        end
    end

    always @(negedge Clk) begin
        for (int g = 0; g < 2; g++) begin
            if (ld[g]) begin
                bc[g]    <= 0;
                rises[g] <= 0;
                bprev[g] <= 1'b0;
            end else begin
                if (busy[g]) bc[g] <= bc[g] + 1;
                if (busy[g] && !bprev[g]) rises[g] <= rises[g] + 1;
                bprev[g] <= busy[g];
            end
        end
    end

    task automatic load(input int g);
        @(posedge Clk); #1 ld[g] = 1'b1;
        @(posedge Clk); #1 ld[g] = 1'b0;
    endtask

    task automatic clear_init(input int g);
        for (int i = 0; i < 16; i++) init[g][i] = 4'd0;
    endtask

    task automatic pulse_tick(input int g);
        @(posedge Clk); #1 tick[g] = 1'b1;
        @(posedge Clk); #1 tick[g] = 1'b0;
    endtask

    task automatic pulse_ack(input int g);
        @(posedge Clk); #1 ack[g] = 1'b1;
        @(posedge Clk); #1 ack[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g, input int max);
        int quiet = 0;
        for (int c = 0; c < max && quiet < 3; c++) begin
            @(negedge Clk);
            quiet = busy[g] ? 0 : quiet + 1;
        end
        checks++;
        if (quiet < 3) begin errors++; $display("FAIL idle_timeout dut%0d: still busy after %0d cycles", g, max); end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        for (int g = 0; g < 2; g++) begin
            checks++;
            if ({re[g], we[g], id[g], wd[g], av[g], amid[g], busy[g]} !== 19'd0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: got %b expected all zero", g,
                         {re[g], we[g], id[g], wd[g], av[g], amid[g], busy[g]});
            end
`ifdef OVERRUN_CNT_EN
            checks++;
            if (ovr[g] !== 8'd0) begin errors++; $display("FAIL reset_overrun dut%0d: got %0d expected 0", g, ovr[g]); end
`endif
        end
        Rst = 1'b0;
    endtask

    task automatic test_basic_scan;
        clear_init(0);
        init[0][0] = 4'd3; init[0][1] = 4'd0; init[0][2] = 4'd1;
        load(0);
        pulse_tick(0);
        wait_idle(0, 100);
        checks++; if (bc[0] !== 15) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 15", bc[0]); end
        checks++; if (wr_cnt[0] !== 2) begin errors++; $display("FAIL basic_write_count: got %0d expected 2", wr_cnt[0]); end
        checks++; if (mem[0][0] !== 4'd2) begin errors++; $display("FAIL basic_id0: got %0d expected 2", mem[0][0]); end
        checks++; if (wr_seen[0][1] !== 1'b0) begin errors++; $display("FAIL basic_id1_written: got %b expected 0", wr_seen[0][1]); end
        checks++; if (mem[0][2] !== 4'd0) begin errors++; $display("FAIL basic_id2: got %0d expected 0", mem[0][2]); end
        checks++; if (av[0] !== 1'b1) begin errors++; $display("FAIL basic_alarm_valid: got %b expected 1", av[0]); end
        checks++; if (amid[0] !== 4'd2) begin errors++; $display("FAIL basic_alarm_id: got %0d expected 2", amid[0]); end
        pulse_ack(0);
        @(negedge Clk);
        checks++; if (av[0] !== 1'b0) begin errors++; $display("FAIL basic_alarm_ack: got %b expected 0", av[0]); end
    endtask

    task automatic test_all_zero;
        clear_init(0);
        load(0);
        pulse_tick(0);
        wait_idle(0, 100);
        checks++; if (bc[0] !== 12) begin errors++; $display("FAIL zero_busy_cycles: got %0d expected 12", bc[0]); end
        checks++; if (wr_cnt[0] !== 0) begin errors++; $display("FAIL zero_write_count: got %0d expected 0", wr_cnt[0]); end
        checks++; if (av[0] !== 1'b0) begin errors++; $display("FAIL zero_alarm: got %b expected 0", av[0]); end
    endtask

    task automatic test_alarm_stall;
        int seen = 0;
        clear_init(0);
        init[0][0] = 4'd1; init[0][1] = 4'd1;
        load(0);
        pulse_tick(0);
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge Clk);
            if (av[0]) seen = 1;
        end
        checks++; if (amid[0] !== 4'd0 || av[0] !== 1'b1) begin errors++; $display("FAIL stall_first_alarm: got valid=%b id=%0d expected valid=1 id=0", av[0], amid[0]); end
        repeat (10) @(negedge Clk);
        checks++; if (busy[0] !== 1'b1 || amid[0] !== 4'd0 || wr_cnt[0] !== 2) begin
            errors++; $display("FAIL stall_hold: got busy=%b id=%0d writes=%0d expected 1 0 2", busy[0], amid[0], wr_cnt[0]);
        end
        pulse_ack(0);
        @(negedge Clk);
        checks++; if (av[0] !== 1'b0) begin errors++; $display("FAIL stall_ack_clear: got %b expected 0", av[0]); end
        @(negedge Clk);
        checks++; if (av[0] !== 1'b1 || amid[0] !== 4'd1) begin errors++; $display("FAIL stall_second_alarm: got valid=%b id=%0d expected valid=1 id=1", av[0], amid[0]); end
        wait_idle(0, 50);
        pulse_ack(0);
    endtask

    task automatic test_back_to_back;
        clear_init(1);
        load(1);
        @(posedge Clk); #1 tick[1] = 1'b1;   // sampled at scan cycle 0
        @(posedge Clk); #1 tick[1] = 1'b0;
        repeat (4) @(posedge Clk);
        #1 tick[1] = 1'b1;                   // sampled at scan cycles 5 and 6
        @(posedge Clk);
        @(posedge Clk); #1 tick[1] = 1'b0;
        wait_idle(1, 400);
        checks++; if (rises[1] !== 2) begin errors++; $display("FAIL b2b_scan_count: got %0d expected 2", rises[1]); end
        checks++; if (bc[1] !== 192) begin errors++; $display("FAIL b2b_busy_cycles: got %0d expected 192", bc[1]); end
        checks++; if (re_cnt[1] !== 32) begin errors++; $display("FAIL b2b_reads: got %0d expected 32", re_cnt[1]); end
`ifdef OVERRUN_CNT_EN
        checks++; if (ovr[1] !== 8'd1) begin errors++; $display("FAIL b2b_overrun: got %0d expected 1", ovr[1]); end
`endif
    endtask

    task automatic test_rst_mid_write;
        int hit = 0;
        clear_init(1);
        init[1][3] = 4'd1; init[1][5] = 4'd7;
        load(1);
        pulse_tick(1);
        pulse_tick(1);   // leaves a tick pending for after this scan
        for (int c = 0; c < 200 && !hit; c++) begin
            @(negedge Clk);
            if (we[1] === 1'b1 && id[1] === 4'd5) hit = 1;
        end
        checks++; if (hit !== 1 || av[1] !== 1'b1 || amid[1] !== 4'd3) begin
            errors++; $display("FAIL rst_pre_state: got hit=%0d valid=%b id=%0d expected 1 1 3", hit, av[1], amid[1]);
        end
        Rst = 1'b1;
        @(negedge Clk);
        checks++; if (we[1] !== 1'b0 || busy[1] !== 1'b0 || av[1] !== 1'b0) begin
            errors++; $display("FAIL rst_outputs: got we=%b busy=%b valid=%b expected 0 0 0", we[1], busy[1], av[1]);
        end
        checks++; if (mem[1][5] !== 4'd7 || wr_seen[1][5] !== 1'b0) begin
            errors++; $display("FAIL rst_id5_kept: got %0d written=%b expected 7 0", mem[1][5], wr_seen[1][5]);
        end
        Rst = 1'b0;
        repeat (5) @(negedge Clk);
        checks++; if (busy[1] !== 1'b0) begin errors++; $display("FAIL rst_pend_cleared: got busy=%b expected 0", busy[1]); end
    endtask

    task automatic test_read_latency;
        clear_init(1);
        init[1][4] = 4'd9;
        load(1);
        pulse_tick(1);
        wait_idle(1, 300);
        checks++; if (mem[1][4] !== 4'd8) begin errors++; $display("FAIL lat_id4: got %0d expected 8", mem[1][4]); end
        checks++; if (wr_cnt[1] !== 1) begin errors++; $display("FAIL lat_write_count: got %0d expected 1", wr_cnt[1]); end
        checks++; if (bc[1] !== 97) begin errors++; $display("FAIL lat_busy_cycles: got %0d expected 97", bc[1]); end
        checks++; if (re_cnt[1] !== 16 || av[1] !== 1'b0) begin
            errors++; $display("FAIL lat_reads_alarm: got reads=%0d valid=%b expected 16 0", re_cnt[1], av[1]);
        end
    endtask

    initial begin
        for (int g = 0; g < 2; g++) begin
            tick[g] = 1'b0; ack[g] = 1'b0; ld[g] = 1'b0;
        end
        test_reset;
        test_basic_scan;
        test_all_zero;
        test_alarm_stall;
        test_back_to_back;
        test_rst_mid_write;
        test_read_latency;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/med_countdown_scanner.md
Name: med_countdown_scanner

Overview:
- Downstream consumer and write-back agent of the medicine time-remaining RAM top (RAM2 top module).
- On each Tick pulse, walks medicine IDs 0..NUM_MEDS-1. For each ID it reads the time-remaining value, decrements non-zero values, writes the result back, and raises a reminder alarm when a value reaches zero.
- Alarms are delivered to the reminder/annunciator logic over a valid/ack handshake.

Parameters:
- NUM_MEDS, 16: number of medicine IDs scanned per tick (1..16); IDs 0..NUM_MEDS-1.
- RD_LAT, 1: RAM read latency in cycles from the Read_En cycle until TimeRemRdIn is valid (1..3).

Ports:
- Clk  in  1  single system clock, rising edge.
- Rst  in  1  synchronous, active-high reset.
- Tick  in  1  one-cycle pulse; starts a scan (e.g. 1-minute timebase).
- Read_En  out  1  RAM read strobe.
- Write_En  out  1  RAM write strobe.
- MedIDOut  out  4  RAM address, used for both read and write.
- TimeRemWrOut  out  4  write data (decremented value).
- TimeRemRdIn  in  4  read data from the RAM top (TimeRemOut).
- Alarm_Valid  out  1  alarm pending.
- Alarm_MedID  out  4  ID whose time reached zero; stable while Alarm_Valid=1.
- Alarm_Ack  in  1  consumer accepts the alarm.
- Busy  out  1  scan in progress.
- Overrun_Cnt  out  8  only when OVERRUN_CNT_EN is defined.

Behaviour:
- Reset values: all outputs 0; FSM=IDLE; idx=0; tick_pend=0.
- Write_En and Read_En are never asserted in the same cycle.
- MedIDOut holds idx in every state except IDLE, where it is 0.
- FSM states:
  - IDLE: Busy=0. If Tick or tick_pend: clear tick_pend, idx=0, go to RD.
  - RD: Read_En=1 for 1 cycle, then WT.
  - WT: hold RD_LAT cycles using an internal counter, then EV.
  - EV: sample TimeRemRdIn into v.
    - v==0: entry is inactive; no write; go to NX.
    - v>=1: go to WR with TimeRemWrOut=v-1. No wrap-around; 0 is never decremented.
  - WR: Write_En=1 for 1 cycle.
    - If v==1 (new value 0): go to AL.
    - Otherwise go to NX.
  - AL: if Alarm_Valid=0, set Alarm_Valid=1 and Alarm_MedID=idx, then go to NX. If a prior alarm is still unacknowledged, stay in AL (scan stalls; no alarm is dropped).
  - NX: if idx==NUM_MEDS-1, go to IDLE; otherwise idx+1, go to RD.
- Busy=1 in every state except IDLE.
- Cycle cost per entry at RD_LAT=1: RD, WT, EV, NX = 4 cycles with no write; add 1 for WR; AL adds at least 1.
- Alarm handshake:
  - Alarm_Valid clears on the cycle after Alarm_Ack=1 is sampled while Alarm_Valid=1.
  - Alarm_Ack while Alarm_Valid=0 is ignored.
  - If Ack clears the alarm in the same cycle the FSM sits in AL, the new alarm loads on the following cycle.
- Tick during a scan (Busy=1): set tick_pend. A further Tick while tick_pend=1 is lost; this counts as overrun.
- Tick in the same cycle the FSM moves NX→IDLE: latched into tick_pend; the next scan starts one cycle later.
- Rst mid-scan: returns to IDLE next cycle and clears strobes, alarm and pending tick. RAM contents are untouched, so a write in flight that cycle is suppressed.
- Alarm_MedID, MedIDOut and TimeRemWrOut are registered outputs.

Optional Feature:
- Macro: OVERRUN_CNT_EN.
- Defined: Overrun_Cnt port exists. It is an 8-bit counter that saturates at 255 and increments each cycle Tick=1 while tick_pend=1 and Busy=1. It is cleared only by Rst.
- Undefined: the port and counter are absent. Lost ticks are silent; all other behaviour is identical.

Test Plan:
- Preload RAM {ID0=3, ID1=0, ID2=1}, NUM_MEDS=3, one Tick:
  - Required writes: ID0←2 and ID2←0; no write to ID1.
  - Alarm_Valid=1 with Alarm_MedID=2.
  - Busy high for exactly 15 cycles.
- All entries 0, Tick → zero Write_En pulses; Busy high 4*NUM_MEDS cycles; no alarm.
- ID0=1 and ID1=1, Alarm_Ack held 0, Tick:
  - Alarm for ID0 is asserted; FSM stalls in AL for ID1.
  - Pulse Ack after 10 cycles → Alarm_MedID=1 within 2 cycles; scan completes.
- Tick pulses at scan cycles 0, 5 and 6 (NUM_MEDS=16):
  - Exactly one extra scan runs back-to-back.
  - Overrun_Cnt=1 with OVERRUN_CNT_EN defined.
- Rst asserted during a WR cycle of ID5:
  - Next cycle Write_En=0, Busy=0, Alarm_Valid=0.
  - ID5 keeps its old RAM value.
- RD_LAT=3, ID4=9, Tick → ID4 read back as 8. TimeRemRdIn is sampled exactly 3 cycles after the Read_En cycle; verify with a scoreboard model of RAM latency.
